// File: rtl/simplecpu_wb_readback.sv
// simplecpu_wb_readback
// Wishbone classic responder that lets the management SoC read simplecpu state
// (PC, A, B, OUT, flags, halt), all 16 RAM bytes through a 1-cycle-latency RAM
// read port, and a small FIFO that captures every CPU OUT write.
// Optional feature macro: SIMPLECPU_RB_IRQ_EN drives irq from a registered
// FIFO-not-empty; without it irq is tied low.
module simplecpu_wb_readback #(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic [3:0]  cpu_pc,
   input  logic [7:0]  cpu_a,
   input  logic [7:0]  cpu_b,
   input  logic [7:0]  cpu_out,
   input  logic        cpu_out_we,
   input  logic        cpu_flag_zero,
   input  logic        cpu_flag_carry,
   input  logic        cpu_halt,
   output logic        ram_rd_en,
   output logic [3:0]  ram_rd_addr,
   input  logic [7:0]  ram_rd_data,
   output logic        irq
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

   localparam logic [7:0] OFF_STATUS = 8'h00;
   localparam logic [7:0] OFF_PC     = 8'h04;
   localparam logic [7:0] OFF_A      = 8'h08;
   localparam logic [7:0] OFF_B      = 8'h0C;
   localparam logic [7:0] OFF_OUT    = 8'h10;
   localparam logic [7:0] OFF_FIFO   = 8'h14;
   localparam logic [7:0] OFF_CTRL   = 8'h18;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RAM_WAIT = 2'd1,
      ST_ACK      = 2'd2
   } state_t;

   state_t           state_r;
   state_t           next_state_s;
   logic [7:0]       off_r;
   logic             we_r;
   logic [1:0]       ctrl_r;
   logic [3:0]       ram_rd_addr_r;
   logic [7:0]       fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             ovf_r;

   logic             req_s;
   logic             ram_hit_s;
   logic             ack_s;
   logic             ram_en_s;
   logic [31:0]      dat_s;
   logic             full_s;
   logic             empty_s;
   logic             ctrl_wr_s;
   logic             flush_s;
   logic             clr_ovf_s;
   logic             pop_s;
   logic             push_ok_s;
   logic             drop_s;
   logic [7:0]       count_ext_s;
   logic [31:0]      status_s;
   logic [31:0]      rd_data_s;
   logic             unused_in_s;

   // Request decode: page match on the upper address bits, RAM window is 0x40..0x7C word-aligned
   assign req_s       = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign ram_hit_s   = !wbs_we_i && (wbs_adr_i[7:6] == 2'b01) && (wbs_adr_i[1:0] == 2'b00);
   assign count_ext_s = 8'(count_r);
   assign status_s    = {23'h00_0000, cpu_halt, cpu_flag_carry, cpu_flag_zero,
                         ovf_r, full_s, empty_s, count_ext_s[2:0]};
   assign unused_in_s = ^{wbs_sel_i, wbs_dat_i[31:2], count_ext_s[7:3]};

   // FSM state register
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state: RAM reads take an extra wait cycle, everything else acks directly
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req_s) begin
               if (ram_hit_s) begin
                  next_state_s = ST_RAM_WAIT;
               end else begin
                  next_state_s = ST_ACK;
               end
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_RAM_WAIT: next_state_s = ST_ACK;
         ST_ACK:      next_state_s = ST_IDLE;
         default:     next_state_s = ST_IDLE;
      endcase
   end

   // FSM outputs: single-cycle ack, read data only while acking a read
   always_comb begin
      ack_s    = 1'b0;
      ram_en_s = 1'b0;
      dat_s    = 32'h0000_0000;
      case (state_r)
         ST_IDLE: begin
            ack_s = 1'b0;
         end
         ST_RAM_WAIT: begin
            ram_en_s = 1'b1;
         end
         ST_ACK: begin
            ack_s = 1'b1;
            if (!we_r) begin
               dat_s = rd_data_s;
            end else begin
               dat_s = 32'h0000_0000;
            end
         end
         default: begin
            ack_s = 1'b0;
         end
      endcase
   end

   assign wbs_ack_o   = ack_s;
   assign wbs_dat_o   = dat_s;
   assign ram_rd_en   = ram_en_s;
   assign ram_rd_addr = ram_rd_addr_r;

   // Capture the accepted request so the ack cycle decodes a stable offset
   always_ff @(posedge clock) begin
      if (!reset) begin
         off_r         <= 8'h00;
         we_r          <= 1'b0;
         ctrl_r        <= 2'b00;
         ram_rd_addr_r <= 4'h0;
      end else if ((state_r == ST_IDLE) && req_s) begin
         off_r  <= wbs_adr_i[7:0];
         we_r   <= wbs_we_i;
         ctrl_r <= wbs_dat_i[1:0];
         if (ram_hit_s) begin
            ram_rd_addr_r <= wbs_adr_i[5:2];
         end
      end
   end

   // Read mux: register values are taken live in the ack cycle
   always_comb begin
      rd_data_s = 32'h0000_0000;
      if ((off_r[7:6] == 2'b01) && (off_r[1:0] == 2'b00)) begin
         rd_data_s = {24'h00_0000, ram_rd_data};
      end else begin
         case (off_r)
            OFF_STATUS: rd_data_s = status_s;
            OFF_PC:     rd_data_s = {28'h000_0000, cpu_pc};
            OFF_A:      rd_data_s = {24'h00_0000, cpu_a};
            OFF_B:      rd_data_s = {24'h00_0000, cpu_b};
            OFF_OUT:    rd_data_s = {24'h00_0000, cpu_out};
            OFF_FIFO:   rd_data_s = empty_s ? 32'h0000_0000 : {24'h00_0000, fifo_mem_r[rd_ptr_r]};
            default:    rd_data_s = 32'h0000_0000;
         endcase
      end
   end

   // FIFO control: a pop frees room for a same-cycle push; flush overrides any push
   always_comb begin
      full_s    = (count_r == DEPTH_CNT);
      empty_s   = (count_r == CNT_W'(0));
      ctrl_wr_s = ack_s && we_r && (off_r == OFF_CTRL);
      flush_s   = ctrl_wr_s && ctrl_r[1];
      clr_ovf_s = ctrl_wr_s && ctrl_r[0];
      pop_s     = ack_s && !we_r && (off_r == OFF_FIFO) && !empty_s;
      push_ok_s = cpu_out_we && (!full_s || pop_s) && !flush_s;
      drop_s    = cpu_out_we && full_s && !pop_s && !flush_s;
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
         ovf_r    <= 1'b0;
      end else if (flush_s) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
         ovf_r    <= clr_ovf_s ? 1'b0 : ovf_r;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_ok_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
         if (clr_ovf_s) begin
            ovf_r <= 1'b0;
         end else if (drop_s) begin
            ovf_r <= 1'b1;
         end
      end
   end

   // FIFO storage; contents are don't-care until pointed at, so no reset needed
   always_ff @(posedge clock) begin
      if (push_ok_s) begin
         fifo_mem_r[wr_ptr_r] <= cpu_out;
      end
   end

`ifdef SIMPLECPU_RB_IRQ_EN
   logic irq_r;

   // Interrupt follows FIFO-not-empty one cycle late
   always_ff @(posedge clock) begin
      if (!reset) begin
         irq_r <= 1'b0;
      end else begin
         irq_r <= !empty_s;
      end
   end

   assign irq = irq_r;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_simplecpu_wb_readback.sv
// Self-checking bench for simplecpu_wb_readback: fixed vector table, hand-written
// FIFO / reset / irq sequences, and a randomized phase against a queue-based model.
module tb_simplecpu_wb_readback;

   localparam logic [31:0] BASE  = 32'h3000_0000;
   localparam int          DEPTH = 4;
`ifdef SIMPLECPU_RB_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i, wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [3:0]  cpu_pc;
   logic [7:0]  cpu_a, cpu_b, cpu_out;
   logic        cpu_out_we, cpu_flag_zero, cpu_flag_carry, cpu_halt;
   logic        ram_rd_en;
   logic [3:0]  ram_rd_addr;
   logic [7:0]  ram_rd_data;
   logic        irq;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  ram_mem [16];
   logic [7:0]  fifo_q [$];
   logic        m_ovf;
   logic [7:0]  reg_offs [8];

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [3:0]  pc;
      logic [7:0]  a;
      logic [2:0]  hcz;
      logic        ack;
      int          lat;
      int          ram_cyc;
      logic [3:0]  ram_addr;
      logic [31:0] dat;
   } vec_t;

   vec_t vecs [17];

   simplecpu_wb_readback #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clk), .reset(reset),
      .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .cpu_pc(cpu_pc), .cpu_a(cpu_a), .cpu_b(cpu_b), .cpu_out(cpu_out),
      .cpu_out_we(cpu_out_we), .cpu_flag_zero(cpu_flag_zero),
      .cpu_flag_carry(cpu_flag_carry), .cpu_halt(cpu_halt),
      .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
      .irq(irq)
   );

   always #5 clk = ~clk;

   // RAM model: data valid the cycle after a strobe, garbage otherwise
   always @(posedge clk) begin
      if (ram_rd_en) ram_rd_data <= ram_mem[ram_rd_addr];
      else           ram_rd_data <= 8'($urandom);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic void model_push(input logic [7:0] v);
      if (fifo_q.size() < DEPTH) fifo_q.push_back(v);
      else m_ovf = 1'b1;
   endfunction

   function automatic logic [31:0] model_status();
      int n;
      n = fifo_q.size();
      return 32'(cpu_halt) * 256 + 32'(cpu_flag_carry) * 128 + 32'(cpu_flag_zero) * 64 +
             32'(m_ovf) * 32 + 32'(n == DEPTH) * 16 + 32'(n == 0) * 8 + 32'(n % 8);
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] off);
      int idx;
      if (off >= 8'h40 && off <= 8'h7C && (off % 4) == 0) begin
         idx = (int'(off) - 64) / 4;
         return 32'(ram_mem[idx]);
      end
      case (off)
         8'h00:   return model_status();
         8'h04:   return 32'(cpu_pc);
         8'h08:   return 32'(cpu_a);
         8'h0C:   return 32'(cpu_b);
         8'h10:   return 32'(cpu_out);
         8'h14:   return (fifo_q.size() > 0) ? 32'(fifo_q[0]) : 32'h0;
         default: return 32'h0;
      endcase
   endfunction

   // CPU OUT write: one-cycle pulse, starting and ending at a falling edge
   task automatic push_byte(input logic [7:0] v);
      cpu_out    = v;
      cpu_out_we = 1'b1;
      @(posedge clk); @(negedge clk);
      cpu_out_we = 1'b0;
      model_push(v);
   endtask

   // Raw bus access from a falling edge; optional OUT push during the ack cycle
   task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                            input logic push_en, input logic [7:0] push_val,
                            output logic got_ack, output int lat, output logic [31:0] rdat,
                            output int ram_cyc, output logic [3:0] ram_addr_seen);
      got_ack = 1'b0; lat = 0; rdat = 32'h0; ram_cyc = 0; ram_addr_seen = 4'h0;
      wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = wdat; wbs_sel_i = 4'hF;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
      for (int c = 1; c <= 6 && !got_ack; c++) begin
         @(posedge clk); @(negedge clk);
         if (ram_rd_en) begin
            ram_cyc++;
            ram_addr_seen = ram_rd_addr;
         end
         if (wbs_ack_o) begin
            got_ack = 1'b1; lat = c; rdat = wbs_dat_o;
            if (push_en) begin
               cpu_out = push_val; cpu_out_we = 1'b1;
            end
         end
      end
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      @(posedge clk); @(negedge clk);
      cpu_out_we = 1'b0;
      check("ack_dropped", {31'h0, wbs_ack_o}, 32'h0);
      check("dat_idle_zero", wbs_dat_o, 32'h0);
   endtask

   // Model-checked access: expectations from the map rules, then model update
   task automatic do_access(input string name, input logic [31:0] adr, input logic we,
                            input logic [31:0] wdat, input logic push_en, input logic [7:0] push_val,
                            output logic [31:0] rdat);
      logic [7:0]  off;
      logic        match, is_ram, got;
      int          lat, ram_cyc, exp_lat;
      logic [3:0]  ra;
      logic [31:0] exp_dat;
      off     = adr[7:0];
      match   = (adr[31:8] == BASE[31:8]);
      is_ram  = match && !we && off >= 8'h40 && off <= 8'h7C && (off % 4) == 0;
      exp_lat = !match ? 0 : (is_ram ? 2 : 1);
      exp_dat = (match && !we) ? model_read(off) : 32'h0;
      wb_access(adr, we, wdat, push_en, push_val, got, lat, rdat, ram_cyc, ra);
      check($sformatf("%s_ack", name), {31'h0, got}, {31'h0, match});
      check($sformatf("%s_lat", name), 32'(lat), 32'(exp_lat));
      check($sformatf("%s_dat", name), rdat, exp_dat);
      check($sformatf("%s_ramcyc", name), 32'(ram_cyc), is_ram ? 32'd1 : 32'd0);
      if (is_ram) check($sformatf("%s_ramaddr", name), 32'(ra), 32'((int'(off) - 64) / 4));
      if (match && !we && off == 8'h14 && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (push_en && match) model_push(push_val);
      if (match && we && off == 8'h18) begin
         if (wdat[0]) m_ovf = 1'b0;
         if (wdat[1]) fifo_q.delete();
      end
   endtask

   initial begin
      logic [31:0] rd, wd, adr;
      logic        got;
      int          lat, rc, sel, idx;
      logic [3:0]  ra;

      reset = 1'b0;
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
      wbs_dat_i = 32'h0; wbs_adr_i = 32'h0;
      cpu_pc = 4'h0; cpu_a = 8'h00; cpu_b = 8'h00; cpu_out = 8'h00; cpu_out_we = 1'b0;
      cpu_flag_zero = 1'b0; cpu_flag_carry = 1'b0; cpu_halt = 1'b0;
      m_ovf = 1'b0;
      for (int i = 0; i < 16; i++) ram_mem[i] = 8'(i * 16 + 7);
      ram_mem[0] = 8'h01; ram_mem[5] = 8'h5E; ram_mem[15] = 8'hF1;
      reg_offs = '{8'h04, 8'h08, 8'h0C, 8'h10, 8'h18, 8'h20, 8'h3C, 8'hFC};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
      check("rst_dat", wbs_dat_o, 32'h0);
      check("rst_ram_en", {31'h0, ram_rd_en}, 32'h0);
      check("rst_ram_addr", {28'h0, ram_rd_addr}, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      do_access("rst_status", BASE | 32'h00, 1'b0, 32'h0, 1'b0, 8'h00, rd);
      check("rst_status_const", rd, 32'h0000_0008);

      // Vector table
      vecs[0]  = '{32'h3000_0004, 1'b0, 4'hA, 8'h3C, 3'b000, 1'b1, 1, 0, 4'h0, 32'h0000_000A};
      vecs[1]  = '{32'h3000_0008, 1'b0, 4'hA, 8'h3C, 3'b000, 1'b1, 1, 0, 4'h0, 32'h0000_003C};
      vecs[2]  = '{32'h3000_000C, 1'b0, 4'hA, 8'h3C, 3'b000, 1'b1, 1, 0, 4'h0, 32'h0000_007E};
      vecs[3]  = '{32'h3000_0010, 1'b0, 4'hA, 8'h3C, 3'b000, 1'b1, 1, 0, 4'h0, 32'h0000_0099};
      vecs[4]  = '{32'h3000_0000, 1'b0, 4'hA, 8'h3C, 3'b110, 1'b1, 1, 0, 4'h0, 32'h0000_0188};
      vecs[5]  = '{32'h3000_0000, 1'b0, 4'hA, 8'h3C, 3'b001, 1'b1, 1, 0, 4'h0, 32'h0000_0048};
      vecs[6]  = '{32'h3000_0054, 1'b0, 4'hA, 8'h3C, 3'b000, 1'b1, 2, 1, 4'h5, 32'h0000_005E};
      vecs[7]  = '{32'h3000_007C, 1'b0, 4'hA, 8'h3C, 3'b000, 1'b1, 2, 1, 4'hF, 32'h0000_00F1};
      vecs[8]  = '{32'h3000_0040, 1'b0, 4'hA, 8'h3C, 3'b000, 1'b1, 2, 1, 4'h0, 32'h0000_0001};
      vecs[9]  = '{32'h3000_0020, 1'b0, 4'hA, 8'h3C, 3'b000, 1'b1, 1, 0, 4'h0, 32'h0000_0000};
      vecs[10] = '{32'h3000_0018, 1'b0, 4'hA, 8'h3C, 3'b000, 1'b1, 1, 0, 4'h0, 32'h0000_0000};
      vecs[11] = '{32'h4000_0000, 1'b0, 4'hA, 8'h3C, 3'b000, 1'b0, 0, 0, 4'h0, 32'h0000_0000};
      vecs[12] = '{32'h3000_0004, 1'b1, 4'h3, 8'h3C, 3'b000, 1'b1, 1, 0, 4'h0, 32'h0000_0000};
      vecs[13] = '{32'h3000_0054, 1'b1, 4'h3, 8'h3C, 3'b000, 1'b1, 1, 0, 4'h0, 32'h0000_0000};
      vecs[14] = '{32'h3000_0014, 1'b0, 4'h3, 8'h3C, 3'b000, 1'b1, 1, 0, 4'h0, 32'h0000_0000};
      vecs[15] = '{32'h3000_0100, 1'b0, 4'h3, 8'h3C, 3'b000, 1'b0, 0, 0, 4'h0, 32'h0000_0000};
      vecs[16] = '{32'h3000_00FC, 1'b0, 4'h6, 8'h3C, 3'b000, 1'b1, 1, 0, 4'h0, 32'h0000_0000};
      cpu_b = 8'h7E; cpu_out = 8'h99;
      for (int v = 0; v < 17; v++) begin
         cpu_pc = vecs[v].pc; cpu_a = vecs[v].a;
         {cpu_halt, cpu_flag_carry, cpu_flag_zero} = vecs[v].hcz;
         wb_access(vecs[v].adr, vecs[v].we, 32'hFFFF_FFFF, 1'b0, 8'h00, got, lat, rd, rc, ra);
         check($sformatf("vec%0d_ack", v), {31'h0, got}, {31'h0, vecs[v].ack});
         check($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].lat));
         check($sformatf("vec%0d_dat", v), rd, vecs[v].dat);
         check($sformatf("vec%0d_ramcyc", v), 32'(rc), 32'(vecs[v].ram_cyc));
         if (vecs[v].ram_cyc > 0) check($sformatf("vec%0d_ramaddr", v), {28'h0, ra}, {28'h0, vecs[v].ram_addr});
      end
      cpu_halt = 1'b0; cpu_flag_carry = 1'b0; cpu_flag_zero = 1'b0;

      // FIFO fill and drain
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
      do_access("fifo3_status", BASE, 1'b0, 32'h0, 1'b0, 8'h00, rd);
      check("fifo3_status_const", rd, 32'h0000_0003);
      do_access("pop1", BASE | 32'h14, 1'b0, 32'h0, 1'b0, 8'h00, rd); check("pop1_const", rd, 32'h11);
      do_access("pop2", BASE | 32'h14, 1'b0, 32'h0, 1'b0, 8'h00, rd); check("pop2_const", rd, 32'h22);
      do_access("pop3", BASE | 32'h14, 1'b0, 32'h0, 1'b0, 8'h00, rd); check("pop3_const", rd, 32'h33);
      do_access("pop_empty", BASE | 32'h14, 1'b0, 32'h0, 1'b0, 8'h00, rd); check("pop_empty_const", rd, 32'h0);

      // Overflow, clear, pop-while-push on full, flush
      for (int i = 1; i <= 5; i++) push_byte(8'(8'hA0 + i));
      do_access("ovf_status", BASE, 1'b0, 32'h0, 1'b0, 8'h00, rd); check("ovf_status_const", rd, 32'h34);
      do_access("clr_ovf", BASE | 32'h18, 1'b1, 32'h1, 1'b0, 8'h00, rd);
      do_access("clr_status", BASE, 1'b0, 32'h0, 1'b0, 8'h00, rd); check("clr_status_const", rd, 32'h14);
      do_access("popfull", BASE | 32'h14, 1'b0, 32'h0, 1'b1, 8'h44, rd); check("popfull_const", rd, 32'hA1);
      do_access("popfull_status", BASE, 1'b0, 32'h0, 1'b0, 8'h00, rd); check("popfull_status_const", rd, 32'h14);
      do_access("tail1", BASE | 32'h14, 1'b0, 32'h0, 1'b0, 8'h00, rd); check("tail1_const", rd, 32'hA2);
      do_access("tail2", BASE | 32'h14, 1'b0, 32'h0, 1'b0, 8'h00, rd); check("tail2_const", rd, 32'hA3);
      do_access("tail3", BASE | 32'h14, 1'b0, 32'h0, 1'b0, 8'h00, rd); check("tail3_const", rd, 32'hA4);
      do_access("tail4", BASE | 32'h14, 1'b0, 32'h0, 1'b0, 8'h00, rd); check("tail4_const", rd, 32'h44);
      push_byte(8'h55); push_byte(8'h66);
      do_access("flush", BASE | 32'h18, 1'b1, 32'h2, 1'b0, 8'h00, rd);
      do_access("flush_status", BASE, 1'b0, 32'h0, 1'b0, 8'h00, rd); check("flush_status_const", rd, 32'h08);

      // irq lag (tied low when the feature is not built)
      cpu_out = 8'h77; cpu_out_we = 1'b1;
      @(posedge clk); @(negedge clk);
      cpu_out_we = 1'b0; model_push(8'h77);
      check("irq_lag0", {31'h0, irq}, 32'h0);
      @(posedge clk); @(negedge clk);
      check("irq_set", {31'h0, irq}, {31'h0, IRQ_ON});
      do_access("irq_pop", BASE | 32'h14, 1'b0, 32'h0, 1'b0, 8'h00, rd);
      check("irq_hold", {31'h0, irq}, {31'h0, IRQ_ON});
      @(posedge clk); @(negedge clk);
      check("irq_clear", {31'h0, irq}, 32'h0);

      // Reset during RAM_WAIT aborts the access and clears the FIFO
      push_byte(8'h99);
      wbs_adr_i = BASE | 32'h54; wbs_we_i = 1'b0; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
      @(posedge clk); @(negedge clk);
      check("abort_in_wait", {31'h0, ram_rd_en}, 32'h1);
      reset = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); @(negedge clk);
         check("abort_no_ack", {31'h0, wbs_ack_o}, 32'h0);
         check("abort_ram_addr", {28'h0, ram_rd_addr}, 32'h0);
      end
      reset = 1'b1; fifo_q.delete(); m_ovf = 1'b0;
      @(posedge clk); @(negedge clk);
      do_access("abort_status", BASE, 1'b0, 32'h0, 1'b0, 8'h00, rd);
      check("abort_status_const", rd, 32'h08);
      check("abort_irq", {31'h0, irq}, 32'h0);

      // Randomized traffic against the queue model
      for (int it = 0; it < 300; it++) begin
         cpu_pc = 4'($urandom); cpu_a = 8'($urandom); cpu_b = 8'($urandom); cpu_out = 8'($urandom);
         cpu_flag_zero = 1'($urandom); cpu_flag_carry = 1'($urandom); cpu_halt = 1'($urandom);
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1: push_byte(8'($urandom));
            2: begin
               wd = {30'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom)};
               do_access("rnd_ctrl", BASE | 32'h18, 1'b1, wd, 1'b0, 8'h00, rd);
            end
            3, 4: do_access("rnd_fifo", BASE | 32'h14, 1'b0, 32'h0, 1'($urandom), 8'($urandom), rd);
            5: do_access("rnd_status", BASE, 1'b0, 32'h0, 1'b0, 8'h00, rd);
            6: begin
               idx = $urandom_range(0, 15);
               ram_mem[idx] = 8'($urandom);
               do_access("rnd_ram", BASE + 32'(64 + 4 * idx), 1'b0, 32'h0, 1'b0, 8'h00, rd);
            end
            7: do_access("rnd_reg", BASE | 32'(reg_offs[$urandom_range(0, 7)]), 1'b0, 32'h0, 1'b0, 8'h00, rd);
            8: do_access("rnd_wr", BASE | 32'(reg_offs[$urandom_range(0, 3)]), 1'b1, $urandom, 1'b0, 8'h00, rd);
            default: begin
               adr = $urandom;
               if (adr[31:8] == BASE[31:8]) adr[31] = ~adr[31];
               do_access("rnd_nomatch", adr, 1'b0, 32'h0, 1'b0, 8'h00, rd);
            end
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
